// File: rtl/alu_control_if.sv
// ---------------------------------------------------------------------------
// alu_control_if
//   Bundles the ID-stage decode request (op, func) and the registered ALU
//   select result (ctrl_op, illegal) that travel between the control unit and
//   the ALU control decoder.
//
//   Signals:
//     func     [5:0]  R-type funct field        (control unit -> decoder)
//     op       [1:0]  ALU operation class       (control unit -> decoder)
//     ctrl_op  [2:0]  registered ALU select     (decoder -> EX stage)
//     illegal         unsupported R-type funct  (decoder -> EX stage)
//
//   Modports:
//     master  - drives op/func, observes the result (control unit, bench)
//     slave   - the decoder itself
// ---------------------------------------------------------------------------
interface alu_control_if;
  logic [5:0] func;
  logic [1:0] op;
  logic [2:0] ctrl_op;
  logic       illegal;

  modport master (
    output func,
    output op,
    input  ctrl_op,
    input  illegal
  );

  modport slave (
    input  func,
    input  op,
    output ctrl_op,
    output illegal
  );
endinterface

// File: rtl/alu_control.sv
// ---------------------------------------------------------------------------
// alu_control
//   Registered ALU control decoder. Combines the 2-bit operation class from
//   the main control unit with the 6-bit R-type funct field and produces the
//   3-bit ALU operation select. The result is registered so it lines up with
//   the ID/EX pipeline boundary: inputs sampled at edge N are visible after
//   edge N and held until edge N+1.
//
//   Ports:
//     Clk   system clock, rising edge
//     Rst   synchronous reset, active-high; forces ctrl_op = AND, illegal = 0
//     bus   alu_control_if.slave
//             op/func in, ctrl_op/illegal out (both straight from flops)
// ---------------------------------------------------------------------------
module alu_control (
  input  logic         Clk,
  input  logic         Rst,
  alu_control_if.slave bus
);

  // ALU select encoding. 3'b100 and 3'b101 are unused and never produced.
  typedef enum logic [2:0] {
    CTRL_AND = 3'b000,
    CTRL_OR  = 3'b001,
    CTRL_ADD = 3'b010,
    CTRL_MUL = 3'b011,
    CTRL_SUB = 3'b110,
    CTRL_SLT = 3'b111
  } ctrl_op_e;

  // Operation classes issued by the main control unit.
  localparam logic [1:0] OP_ADD   = 2'b00;  // addi, lw, sw
  localparam logic [1:0] OP_SUB   = 2'b01;  // beq compare
  localparam logic [1:0] OP_RTYPE = 2'b10;  // decode funct
  localparam logic [1:0] OP_OR    = 2'b11;  // ori

  // Supported R-type funct codes.
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;
  localparam logic [5:0] FUNC_MUL = 6'b011000;

  ctrl_op_e ctrl_next;
  logic     illegal_next;
  ctrl_op_e ctrl_q;
  logic     illegal_q;

  // Pure function of (op, func); no other state feeds the decode.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    ctrl_next    = CTRL_ADD;
    illegal_next = 1'b0;
    case (bus.op)
      OP_ADD: ctrl_next = CTRL_ADD;
      OP_SUB: ctrl_next = CTRL_SUB;
      OP_RTYPE: begin
        case (bus.func)
          FUNC_ADD: ctrl_next = CTRL_ADD;
          FUNC_SUB: ctrl_next = CTRL_SUB;
          FUNC_AND: ctrl_next = CTRL_AND;
          FUNC_OR:  ctrl_next = CTRL_OR;
          FUNC_SLT: ctrl_next = CTRL_SLT;
          FUNC_MUL: ctrl_next = CTRL_MUL;
          default: begin
            // Unsupported funct: fall back to ADD and flag it.
            ctrl_next    = CTRL_ADD;
            illegal_next = 1'b1;
          end
        endcase
      end
      OP_OR:   ctrl_next = CTRL_OR;
      default: ctrl_next = CTRL_ADD;  // X/Z on op: keep outputs defined
    endcase
  end

  // Loads on every edge; reset wins over decode and discards it (no replay).
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (Rst) begin
      ctrl_q    <= CTRL_AND;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_next;
      illegal_q <= illegal_next;
    end
  end

  assign bus.ctrl_op = ctrl_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_control.sv
// ---------------------------------------------------------------------------
// tb_alu_control
//   Directed testbench for alu_control. Each vector drives (Rst, op, func)
//   shortly after a rising edge, waits for the next edge, then compares
//   {illegal, ctrl_op} against a hand-computed value.
// ---------------------------------------------------------------------------
module tb_alu_control;

  logic Clk;
  logic Rst;

  alu_control_if bus_if ();

  alu_control dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Compares {illegal, ctrl_op} against the expected pair.
  task automatic check(input string tag, input logic [3:0] actual,
                       input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got illegal/ctrl_op=%b expected %b", tag, actual, expected);
    end
  endtask

  // Drives one vector, lets one rising edge take it, then checks 1 ns later.
  task automatic apply(input string tag, input logic rst, input logic [1:0] op,
                       input logic [5:0] func, input logic [2:0] exp_ctrl,
                       input logic exp_ill);
    Rst         = rst;
    bus_if.op   = op;
    bus_if.func = func;
    @(posedge Clk);
    #1;
    check(tag, {bus_if.illegal, bus_if.ctrl_op}, {exp_ill, exp_ctrl});
  endtask

  initial begin
    Rst         = 1'b1;
    bus_if.op   = 2'b10;
    bus_if.func = 6'b100010;
    #1;

    // Reset held for two edges while an R-type SUB sits on the inputs.
    apply("rst_edge1", 1'b1, 2'b10, 6'b100010, 3'b000, 1'b0);
    apply("rst_edge2", 1'b1, 2'b10, 6'b100010, 3'b000, 1'b0);
    apply("rst_release", 1'b0, 2'b10, 6'b100010, 3'b110, 1'b0);

    // op classes that ignore func.
    apply("ori_or_func",  1'b0, 2'b11, 6'b100101, 3'b001, 1'b0);
    apply("ori_zero_func", 1'b0, 2'b11, 6'b000000, 3'b001, 1'b0);
    apply("addi_slt_func", 1'b0, 2'b00, 6'b101010, 3'b010, 1'b0);
    apply("beq_and_func", 1'b0, 2'b01, 6'b100100, 3'b110, 1'b0);
    apply("addi_bad_func", 1'b0, 2'b00, 6'b111111, 3'b010, 1'b0);
    apply("beq_bad_func", 1'b0, 2'b01, 6'b000001, 3'b110, 1'b0);

    // R-type sweep on consecutive edges.
    apply("r_add", 1'b0, 2'b10, 6'b100000, 3'b010, 1'b0);
    apply("r_sub", 1'b0, 2'b10, 6'b100010, 3'b110, 1'b0);
    apply("r_and", 1'b0, 2'b10, 6'b100100, 3'b000, 1'b0);
    apply("r_or",  1'b0, 2'b10, 6'b100101, 3'b001, 1'b0);
    apply("r_slt", 1'b0, 2'b10, 6'b101010, 3'b111, 1'b0);
    apply("r_mul", 1'b0, 2'b10, 6'b011000, 3'b011, 1'b0);

    // Unsupported funct, then recovery on the next edge.
    apply("r_illegal", 1'b0, 2'b10, 6'b111111, 3'b010, 1'b1);
    apply("r_recover", 1'b0, 2'b10, 6'b100000, 3'b010, 1'b0);
    apply("r_illegal_zero", 1'b0, 2'b10, 6'b000000, 3'b010, 1'b1);

    // Constant inputs hold the outputs.
    apply("hold_a", 1'b0, 2'b10, 6'b101010, 3'b111, 1'b0);
    apply("hold_b", 1'b0, 2'b10, 6'b101010, 3'b111, 1'b0);

    // Mid-cycle input changes must not reach the outputs before the edge.
    bus_if.op   = 2'b10;
    bus_if.func = 6'b111111;
    #3;
    check("mid_cycle_a", {bus_if.illegal, bus_if.ctrl_op}, 4'b0111);
    bus_if.op   = 2'b01;
    bus_if.func = 6'b100100;
    #2;
    check("mid_cycle_b", {bus_if.illegal, bus_if.ctrl_op}, 4'b0111);
    bus_if.op   = 2'b11;
    @(posedge Clk);
    #1;
    check("mid_cycle_last", {bus_if.illegal, bus_if.ctrl_op}, 4'b0001);

    // Reset mid-stream: one cycle of 000/0, then the current inputs decode.
    apply("mid_add",    1'b0, 2'b10, 6'b100000, 3'b010, 1'b0);
    apply("mid_rst",    1'b1, 2'b10, 6'b100010, 3'b000, 1'b0);
    apply("mid_resume", 1'b0, 2'b10, 6'b100010, 3'b110, 1'b0);
    apply("mid_next",   1'b0, 2'b10, 6'b101010, 3'b111, 1'b0);
    apply("rst_over_illegal", 1'b1, 2'b10, 6'b111111, 3'b000, 1'b0);
    apply("post_rst_illegal", 1'b0, 2'b10, 6'b111111, 3'b010, 1'b1);
    apply("rst_over_ori", 1'b1, 2'b11, 6'b000000, 3'b000, 1'b0);
    apply("post_rst_ori", 1'b0, 2'b11, 6'b000000, 3'b001, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
